// File: rtl/program_loader.sv
// program_loader: streams a program into instruction memory, verifies it by readback sum,
// then pulses the PC reset and enables fetch.
module program_loader #(
   parameter int ADDR_WIDTH = 8,
   parameter int BASE_ADDR  = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   length,
   input  logic                  in_valid,
   input  logic [31:0]           in_data,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [31:0]           mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata,
   output logic                  pc_enable,
   output logic                  pc_reset,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [31:0]           checksum
);
   localparam logic [31:0] BASE  = 32'(BASE_ADDR);
   localparam logic [32:0] LIMIT = 33'(2**ADDR_WIDTH);

   typedef enum logic [2:0] {IDLE, LOAD, VERIFY, CHECK, RELEASE, DONE, ERROR} state_t;

   state_t              state;
   logic [ADDR_WIDTH:0] len;
   logic [ADDR_WIDTH:0] cnt;
   logic [31:0]         rsum;
   logic                oob;

   assign oob = {1'b0, BASE} + 33'(length) > LIMIT;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         len       <= '0;
         cnt       <= '0;
         rsum      <= '0;
         in_ready  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= BASE;
         mem_wdata <= '0;
         pc_enable <= 1'b0;
         pc_reset  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         checksum  <= '0;
      end else begin
         case (state)
            IDLE, DONE, ERROR: begin
               if (start) begin
                  len       <= length;
                  cnt       <= '0;
                  rsum      <= '0;
                  checksum  <= '0;
                  pc_enable <= 1'b0;
                  done      <= 1'b0;
                  error     <= 1'b0;
                  if (oob) begin
                     state <= ERROR;
                     error <= 1'b1;
                  end else if (length == '0) begin
                     state    <= RELEASE;
                     pc_reset <= 1'b1;
                     busy     <= 1'b1;
                  end else begin
                     state    <= LOAD;
                     in_ready <= 1'b1;
                     busy     <= 1'b1;
                  end
               end
            end
            LOAD: begin
               mem_we <= 1'b0;
               if (in_valid && in_ready) begin
                  mem_we    <= 1'b1;
                  mem_addr  <= BASE + 32'(cnt);
                  mem_wdata <= in_data;
                  checksum  <= checksum + in_data;
                  cnt       <= cnt + 1'b1;
                  if (cnt + 1'b1 == len) in_ready <= 1'b0;
               end else if (mem_we && !in_ready) begin
                  // final write commits on this edge; readback starts from the base
                  state    <= VERIFY;
                  mem_addr <= BASE;
                  cnt      <= '0;
               end
            end
            VERIFY: begin
               rsum     <= rsum + mem_rdata;
               cnt      <= cnt + 1'b1;
               mem_addr <= BASE + 32'(cnt + 1'b1);
               if (cnt + 1'b1 == len) state <= CHECK;
            end
            CHECK: begin
               if (rsum == checksum) begin
                  state    <= RELEASE;
                  pc_reset <= 1'b1;
               end else begin
                  state <= ERROR;
                  error <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            RELEASE: begin
               state     <= DONE;
               pc_reset  <= 1'b0;
               pc_enable <= 1'b1;
               done      <= 1'b1;
               busy      <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed and randomized loads checked against a queue-based reference model.
module tb_program_loader;
   logic        clk = 1'b0;
   logic        reset, start, in_valid;
   logic [8:0]  length;
   logic [31:0] in_data, mem_addr, mem_wdata, mem_rdata, checksum;
   logic        in_ready, mem_we, pc_enable, pc_reset, busy, done, error;

   logic [31:0] mem [0:255];
   logic        corrupt = 1'b0;
   int          we_cnt = 0;
   int          prs_cnt = 0;
   int          compared = 0;
   int          failed = 0;
   logic [31:0] words[$];
   int          gaps[$];

   program_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut (
      .clk(clk), .reset(reset), .start(start), .length(length),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .pc_enable(pc_enable), .pc_reset(pc_reset), .busy(busy), .done(done),
      .error(error), .checksum(checksum)
   );

   always #5 clk = ~clk;

   // memory model; address 2 can be made to read back with bit 0 flipped
   assign mem_rdata = (mem_addr < 32'd256)
      ? mem[mem_addr[7:0]] ^ {31'b0, corrupt && mem_addr == 32'd2} : 32'h0;

   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr[7:0]] <= mem_wdata;
         we_cnt <= we_cnt + 1;
      end
      if (pc_reset) prs_cnt <= prs_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_values();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_pc_enable", pc_enable, 0);
      chk("rst_pc_reset", pc_reset, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_checksum", checksum, 0);
   endtask

   // Loads `words` with `gaps[i]` idle cycles before word i; edge 0 is the start edge.
   task automatic run_load(input bit bad);
      int L = words.size();
      int g = 0;
      int n;
      int pr_edge = -1;
      int we0 = we_cnt;
      int pr0 = prs_cnt;
      int nbad = 0;
      logic [31:0] sum = 0;
      foreach (words[i]) begin
         sum += words[i];
         g += gaps[i];
      end
      corrupt = bad;
      start = 1'b1;
      length = 9'(L);
      tick();
      start = 1'b0;
      chk("load_busy", busy, 1);
      chk("load_in_ready", in_ready, 1);
      foreach (words[i]) begin
         repeat (gaps[i]) begin
            in_valid = 1'b0;
            in_data = $urandom;
            tick();
         end
         in_valid = 1'b1;
         in_data = words[i];
         chk("ready_when_valid", in_ready, 1);
         tick();
      end
      in_valid = 1'b0;
      n = L + g;
      chk("ready_drops", in_ready, 0);
      chk("load_checksum", checksum, sum);
      while (!(done || error) && n < 3 * L + g + 20) begin
         if (pc_reset) pr_edge = n;
         tick();
         n++;
      end
      chk("end_edge", n, bad ? 2 * L + g + 2 : 2 * L + g + 3);
      chk("done", done, !bad);
      chk("error", error, bad);
      chk("pc_enable", pc_enable, !bad);
      chk("busy_end", busy, 0);
      chk("we_pulses", we_cnt - we0, L);
      chk("pc_reset_pulses", prs_cnt - pr0, bad ? 0 : 1);
      if (!bad) chk("pc_reset_edge", pr_edge, 2 * L + g + 2);
      chk("final_checksum", checksum, sum);
      foreach (words[i]) if (mem[i] !== words[i]) nbad++;
      chk("mem_contents", nbad, 0);
      corrupt = 1'b0;
   endtask

   task automatic set_words(input int L, input int maxgap);
      words.delete();
      gaps.delete();
      for (int i = 0; i < L; i++) begin
         words.push_back($urandom);
         gaps.push_back($urandom_range(maxgap, 0));
      end
   endtask

   initial begin
      int we0;
      reset = 1'b1;
      start = 1'b0;
      length = '0;
      in_valid = 1'b0;
      in_data = '0;
      tick();
      chk_reset_values();
      tick();
      reset = 1'b0;

      words = '{32'h20080005, 32'h20090003, 32'h01095020, 32'hAC0A0000};
      gaps = '{0, 0, 0, 0};
      run_load(1'b0);
      gaps = '{0, 1, 1, 1};
      run_load(1'b0);
      run_load(1'b1);

      we0 = we_cnt;
      start = 1'b1;
      length = 9'd257;
      tick();
      start = 1'b0;
      chk("oob_error", error, 1);
      chk("oob_in_ready", in_ready, 0);
      chk("oob_busy", busy, 0);
      chk("oob_pc_enable", pc_enable, 0);
      repeat (3) tick();
      chk("oob_no_writes", we_cnt - we0, 0);

      start = 1'b1;
      length = 9'd0;
      tick();
      start = 1'b0;
      chk("len0_pc_reset", pc_reset, 1);
      chk("len0_mem_we", mem_we, 0);
      chk("len0_error", error, 0);
      tick();
      chk("len0_done", done, 1);
      chk("len0_pc_enable", pc_enable, 1);
      chk("len0_pc_reset_off", pc_reset, 0);
      chk("len0_checksum", checksum, 0);
      chk("len0_no_writes", we_cnt - we0, 0);

      set_words(4, 0);
      start = 1'b1;
      length = 9'd4;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         in_data = words[i];
         tick();
      end
      in_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_reset_values();
      chk("kept_word0", mem[0], words[0]);
      chk("kept_word1", mem[1], words[1]);
      set_words(4, 0);
      run_load(1'b0);

      for (int k = 0; k < 6; k++) begin
         int L = $urandom_range(16, 1);
         set_words(L, 2);
         run_load(L >= 3 && $urandom_range(2, 0) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end
endmodule
